// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous word memory.
// Each granted request takes three cycles: IDLE (latch), ACCESS (memory sees command), RESP (capture read data).
module dmem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic [29:0] m0_addr,
    input  logic [3:0]  m0_wmask,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [29:0] m1_addr,
    input  logic [3:0]  m1_wmask,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    logic   owner;       // port that owns the in-flight transaction
    logic   last_grant;  // port granted most recently, drives round-robin
    logic   winner;

    // Winner for this IDLE cycle; only meaningful when some valid is high.
    always_comb begin
        winner = 1'b0;
        if (m0_valid && m1_valid) begin
            if (FIXED_PRIO) begin
                winner = 1'b0;
            end else begin
                winner = ~last_grant;
            end
        end else if (m1_valid) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            mem_addr   <= '0;
            mem_wmask  <= '0;
            mem_wdata  <= '0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        owner      <= winner;
                        last_grant <= winner;
                        mem_addr   <= winner ? m1_addr  : m0_addr;
                        mem_wmask  <= winner ? m1_wmask : m0_wmask;
                        mem_wdata  <= winner ? m1_wdata : m0_wdata;
                        state      <= ACCESS;
                    end else begin
                        mem_wmask <= '0;
                    end
                end
                ACCESS: begin
                    // Write enable lives for exactly this one cycle.
                    mem_wmask <= '0;
                    state     <= RESP;
                end
                RESP: begin
                    if (owner) begin
                        m1_ready <= 1'b1;
                        m1_rdata <= mem_rdata;
                    end else begin
                        m0_ready <= 1'b1;
                        m0_rdata <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_wmask <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 round-robin, instance 1 fixed priority, each with its own memory.
// A transaction-level model predicts grants and data; a negedge monitor compares against a scoreboard.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        valid [2][2];
    logic [29:0] addr  [2][2];
    logic [3:0]  wmask [2][2];
    logic [31:0] wdata [2][2];

    logic [1:0][1:0]        ready_p;
    logic [1:0][1:0][31:0]  rdata_p;
    logic [1:0][29:0]       mem_addr_p;
    logic [1:0][3:0]        mem_wmask_p;
    logic [1:0][31:0]       mem_wdata_p;

    typedef struct {
        logic        port;
        logic        is_rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb [2][$];
    logic [31:0] refmem [int];
    int          cyc = 0;
    logic        last_g  [2];
    int          free_at [2];
    logic        pend_on [2];
    logic [29:0] pend_a  [2];
    logic [3:0]  pend_m  [2];
    logic [31:0] pend_d  [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   to_events = 0;
    int   to_seen   = 0;
    logic done = 1'b0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [31:0] rd_q;
        logic [31:0] ram [int];

        dmem_arbiter #(.FIXED_PRIO(gi == 1)) dut (
            .clk       (clk),
            .rst       (rst),
            .m0_valid  (valid[gi][0]),
            .m0_addr   (addr[gi][0]),
            .m0_wmask  (wmask[gi][0]),
            .m0_wdata  (wdata[gi][0]),
            .m0_ready  (ready_p[gi][0]),
            .m0_rdata  (rdata_p[gi][0]),
            .m1_valid  (valid[gi][1]),
            .m1_addr   (addr[gi][1]),
            .m1_wmask  (wmask[gi][1]),
            .m1_wdata  (wdata[gi][1]),
            .m1_ready  (ready_p[gi][1]),
            .m1_rdata  (rdata_p[gi][1]),
            .mem_addr  (mem_addr_p[gi]),
            .mem_wmask (mem_wmask_p[gi]),
            .mem_wdata (mem_wdata_p[gi]),
            .mem_rdata (rd_q)
        );

        // Synchronous memory: read returns the pre-write word, writes are byte-masked.
        initial begin
            rd_q = '0;
            forever begin
                logic [31:0] w;
                int          a;
                @(posedge clk);
                a = int'(mem_addr_p[gi][5:0]);
                w = ram.exists(a) ? ram[a] : 32'h0;
                rd_q <= w;
                if (mem_wmask_p[gi] != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wmask_p[gi][b]) w[8*b +: 8] = mem_wdata_p[gi][8*b +: 8];
                    ram[a] = w;
                end
            end
        end
    end

    function automatic logic [31:0] ref_rd(int k);
        return refmem.exists(k) ? refmem[k] : 32'h0;
    endfunction

    // Reference model: one grant at a time, next grant possible three edges later.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    sb[i].delete();
                    pend_on[i] = 1'b0;
                    last_g[i]  = 1'b1;
                    free_at[i] = 0;
                end
            end else begin
                cyc++;
                for (int i = 0; i < 2; i++) begin
                    if (pend_on[i]) begin
                        logic [31:0] w;
                        w = ref_rd(i*64 + int'(pend_a[i][5:0]));
                        for (int b = 0; b < 4; b++)
                            if (pend_m[i][b]) w[8*b +: 8] = pend_d[i][8*b +: 8];
                        refmem[i*64 + int'(pend_a[i][5:0])] = w;
                        pend_on[i] = 1'b0;
                    end
                    if (cyc >= free_at[i] && (valid[i][0] || valid[i][1])) begin
                        logic w_port;
                        exp_t e;
                        if (valid[i][0] && valid[i][1])
                            w_port = (i == 1) ? 1'b0 : ~last_g[i];
                        else
                            w_port = valid[i][1];
                        last_g[i]  = w_port;
                        free_at[i] = cyc + 3;
                        e.port  = w_port;
                        e.cyc   = cyc + 2;
                        e.is_rd = (wmask[i][w_port] == 4'h0);
                        e.data  = ref_rd(i*64 + int'(addr[i][w_port][5:0]));
                        if (!e.is_rd) begin
                            pend_on[i] = 1'b1;
                            pend_a[i]  = addr[i][w_port];
                            pend_m[i]  = wmask[i][w_port];
                            pend_d[i]  = wdata[i][w_port];
                        end
                        sb[i].push_back(e);
                    end
                end
            end
        end
    end

    // Monitor: all DUT outputs sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    n_tests++;
                    if (ready_p[i] != 2'b00 || rdata_p[i] != '0 || mem_wmask_p[i] != 4'h0 ||
                        mem_addr_p[i] != 30'h0 || mem_wdata_p[i] != 32'h0) begin
                        n_fail++;
                        $display("FAIL reset_outputs inst%0d: ready=%b rdata0=%h rdata1=%h wmask=%h addr=%h wdata=%h, required all zero",
                                 i, ready_p[i], rdata_p[i][0], rdata_p[i][1], mem_wmask_p[i], mem_addr_p[i], mem_wdata_p[i]);
                    end
                end else begin
                    logic [3:0] exp_m;
                    exp_m = pend_on[i] ? pend_m[i] : 4'h0;
                    n_tests++;
                    if (mem_wmask_p[i] != exp_m) begin
                        n_fail++;
                        $display("FAIL mem_wmask inst%0d cyc%0d: got %h, required %h", i, cyc, mem_wmask_p[i], exp_m);
                    end
                    if (pend_on[i]) begin
                        n_tests++;
                        if (mem_addr_p[i] != pend_a[i] || mem_wdata_p[i] != pend_d[i]) begin
                            n_fail++;
                            $display("FAIL mem_cmd inst%0d cyc%0d: got addr=%h data=%h, required addr=%h data=%h",
                                     i, cyc, mem_addr_p[i], mem_wdata_p[i], pend_a[i], pend_d[i]);
                        end
                    end
                    for (int p = 0; p < 2; p++) begin
                        if (!ready_p[i][p]) begin
                            n_tests++;
                            if (rdata_p[i][p] != 32'h0) begin
                                n_fail++;
                                $display("FAIL idle_rdata inst%0d port%0d: got %h, required 0", i, p, rdata_p[i][p]);
                            end
                        end
                    end
                    if (ready_p[i] != 2'b00) begin
                        n_tests++;
                        if (ready_p[i] == 2'b11) begin
                            n_fail++;
                            $display("FAIL ready_overlap inst%0d cyc%0d: got ready=11, required one-hot", i, cyc);
                        end else if (sb[i].size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_ready inst%0d cyc%0d: got ready=%b, required none", i, cyc, ready_p[i]);
                        end else begin
                            exp_t e;
                            logic gp;
                            e  = sb[i].pop_front();
                            gp = ready_p[i][1];
                            if (gp != e.port || cyc != e.cyc ||
                                (e.is_rd && rdata_p[i][gp] != e.data)) begin
                                n_fail++;
                                $display("FAIL completion inst%0d: got port=%0d cyc=%0d rdata=%h, required port=%0d cyc=%0d rdata=%h%s",
                                         i, gp, cyc, rdata_p[i][gp], e.port, e.cyc, e.data, e.is_rd ? "" : " (write)");
                            end else begin
                                $display("[TB] inst%0d port%0d %s done cyc=%0d rdata=%h",
                                         i, gp, e.is_rd ? "read" : "write", cyc, rdata_p[i][gp]);
                            end
                        end
                    end
                end
            end
            if (to_events != to_seen) begin
                n_tests++;
                n_fail++;
                $display("FAIL ready_timeout: got no ready within 20 cycles, required a completion");
                to_seen = to_events;
            end
            if (done) begin
                for (int i = 0; i < 2; i++) begin
                    n_tests++;
                    if (sb[i].size() != 0) begin
                        n_fail++;
                        $display("FAIL missing_ready inst%0d: got %0d outstanding, required 0", i, sb[i].size());
                    end
                end
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int p, logic v, logic [29:0] a, logic [3:0] m, logic [31:0] d);
        for (int i = 0; i < 2; i++) begin
            valid[i][p] = v;
            addr[i][p]  = a;
            wmask[i][p] = m;
            wdata[i][p] = d;
        end
    endtask

    task automatic txn(int p, logic [29:0] a, logic [3:0] m, logic [31:0] d);
        int k;
        k = 0;
        set_req(p, 1'b1, a, m, d);
        do begin
            step();
            k++;
        end while (!ready_p[0][p] && k < 20);
        if (!ready_p[0][p]) to_events++;
        set_req(p, 1'b0, a, m, d);
    endtask

    task automatic new_req(int i, int p);
        valid[i][p] = 1'b1;
        addr[i][p]  = 30'($urandom_range(0, 63));
        wmask[i][p] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        wdata[i][p] = $urandom;
    endtask

    initial begin
        logic got0, got1;
        int   k;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        #1 rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        txn(0, 30'h10, 4'hF, 32'hDEADBEEF);
        txn(0, 30'h10, 4'h0, 32'h0);
        txn(0, 30'h5, 4'hF, 32'h11223344);
        txn(0, 30'h5, 4'h2, 32'h0000AB00);
        txn(0, 30'h5, 4'h0, 32'h0);
        txn(1, 30'h7, 4'hF, 32'h12345678);

        // Reset lands in the ACCESS cycle of a write: no completion, no memory update.
        set_req(0, 1'b1, 30'h7, 4'hF, 32'hCAFEF00D);
        step();
        rst = 1'b1;
        set_req(0, 1'b0, 30'h7, 4'h0, 32'h0);
        repeat (2) step();
        rst = 1'b0;

        // First tie after reset must go to port 0.
        set_req(0, 1'b1, 30'h7, 4'h0, 32'h0);
        set_req(1, 1'b1, 30'h5, 4'h0, 32'h0);
        got0 = 1'b0;
        got1 = 1'b0;
        k = 0;
        while (!(got0 && got1) && k < 30) begin
            step();
            k++;
            if (ready_p[0][0]) begin got0 = 1'b1; set_req(0, 1'b0, '0, '0, '0); end
            if (ready_p[0][1]) begin got1 = 1'b1; set_req(1, 1'b0, '0, '0, '0); end
        end
        if (!(got0 && got1)) to_events++;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);

        // m1 withdraws during RESP: one completion, no second grant.
        set_req(1, 1'b1, 30'h10, 4'h0, 32'h0);
        repeat (2) step();
        set_req(1, 1'b0, 30'h10, 4'h0, 32'h0);
        repeat (4) step();

        // Both ports continuously requesting, then randomized traffic with occasional withdrawals.
        for (int i = 0; i < 2; i++) begin
            new_req(i, 0);
            new_req(i, 1);
        end
        for (int c = 0; c < 460; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (ready_p[i][p]) begin
                        if (c < 60 || $urandom_range(0, 1) == 1) new_req(i, p);
                        else valid[i][p] = 1'b0;
                    end else if (!valid[i][p]) begin
                        if ($urandom_range(0, 2) == 0) new_req(i, p);
                    end else if (c >= 60 && $urandom_range(0, 39) == 0) begin
                        valid[i][p] = 1'b0;
                    end
                end
            end
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (8) step();
        done = 1'b1;
        repeat (4) step();
        $display("FAIL end_of_test: got no summary from monitor, required monitor to finish");
        $fatal(1, "monitor did not finish");
    end

endmodule
